camera_strobe_monitor: RTL and testbench

Receive-side checker for the camera trigger path in `trig_ctrl`. It observes the `trig_to_camera` waveform driven by the trigger delay controller and the camera's returned exposure strobe. For every trigger it measures trigger-to-strobe latency and strobe width, and counts received frames, missed frames and overlaps. Results go to the register bank and the debug ILA.

---
 rtl/trig_ctrl_pkg.sv | 29 ++
 rtl/camera_strobe_monitor_if.sv | 49 ++++
 rtl/sync_edge_det.sv | 42 ++++
 rtl/camera_strobe_monitor.sv | 230 +++++++++++++++++++++++
 tb/tb_camera_strobe_monitor.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/trig_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trig_ctrl_pkg
//  Description : Shared types and constants for the trig_ctrl camera trigger
//                path (strobe monitor state encoding, counter ceiling,
//                synchronizer default depth, saturating increment helper).
//  Revision    : 1.0  initial release
// ============================================================================
package trig_ctrl_pkg;

    // Default depth of the camera strobe synchronizer.
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    // Ceiling for every 32-bit measurement and statistics counter.
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_STROBE = 2'd1,
        ST_IN_STROBE   = 2'd2
    } strobe_mon_state_t;

    // Increment that sticks at CNT_MAX instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/camera_strobe_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : camera_strobe_monitor_if
//  Description : Signal bundle between the trigger path / register bank and
//                the camera strobe monitor.
//                mon    : view taken by the monitor (inputs in, results out)
//                master : view taken by whoever drives the trigger/strobe
//                         and reads the results
//  Signals     : trig_to_camera, camera_strobe, reg_strobe_timeout[31:0],
//                reg_camera_trig_num[31:0], clear           (to monitor)
//                strobe_latency[31:0], latency_valid, strobe_width[31:0],
//                width_valid, frame_cnt[31:0], miss_cnt[31:0],
//                overlap_cnt[31:0], timeout_err, burst_done, busy
//                                                           (from monitor)
//  Revision    : 1.0  initial release
// ============================================================================
interface camera_strobe_monitor_if;
    logic        trig_to_camera;
    logic        camera_strobe;
    logic [31:0] reg_strobe_timeout;
    logic [31:0] reg_camera_trig_num;
    logic        clear;

    logic [31:0] strobe_latency;
    logic        latency_valid;
    logic [31:0] strobe_width;
    logic        width_valid;
    logic [31:0] frame_cnt;
    logic [31:0] miss_cnt;
    logic [31:0] overlap_cnt;
    logic        timeout_err;
    logic        burst_done;
    logic        busy;

    modport mon (
        input  trig_to_camera, camera_strobe, reg_strobe_timeout,
               reg_camera_trig_num, clear,
        output strobe_latency, latency_valid, strobe_width, width_valid,
               frame_cnt, miss_cnt, overlap_cnt, timeout_err, burst_done, busy
    );

    modport master (
        output trig_to_camera, camera_strobe, reg_strobe_timeout,
               reg_camera_trig_num, clear,
        input  strobe_latency, latency_valid, strobe_width, width_valid,
               frame_cnt, miss_cnt, overlap_cnt, timeout_err, burst_done, busy
    );
endinterface
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_det
//  Description : N-flop synchronizer for an asynchronous input followed by
//                rise/fall detection against a one-cycle delayed copy of the
//                synchronized level.
//  Ports       : clk, rst      clock, synchronous active-high reset
//                i_async       asynchronous input pin
//                o_rise        synchronized level went 0->1 this cycle
//                o_fall        synchronized level went 1->0 this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module sync_edge_det #(
    parameter int unsigned STAGES = 2   // must be at least 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_rise,
    output logic      o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_sync_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[STAGES-2:0], i_async};
            r_sync_d <= r_sync[STAGES-1];
        end
    end

    // Edges are decoded from two flops, so they are glitch-free and line up
    // with the clock edge on which the consumer acts.
    assign o_rise = r_sync[STAGES-1] & ~r_sync_d;
    assign o_fall = ~r_sync[STAGES-1] & r_sync_d;

endmodule
`default_nettype wire

// File: rtl/camera_strobe_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : camera_strobe_monitor
//  Description : Receive-side checker for the camera trigger path. Measures
//                trigger-to-strobe latency and strobe width for every
//                trigger, and keeps saturating counts of received frames,
//                missed frames (timeouts + retriggers) and overlaps, plus
//                burst completion.
//  Ports       : clk, rst      clock, synchronous active-high reset
//                bus (mon)     trigger/strobe inputs, register settings,
//                              clear, measurement and statistics outputs
//  Revision    : 1.0  initial release
// ============================================================================
module camera_strobe_monitor
    import trig_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  wire logic            clk,
    input  wire logic            rst,
    camera_strobe_monitor_if.mon bus
);

    // ---------------------------------------------------------------- edges
    logic r_trig_q;
    logic w_trig_rise;
    logic w_strb_rise;
    logic w_strb_fall;

    assign w_trig_rise = bus.trig_to_camera & ~r_trig_q;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.camera_strobe),
        .o_rise  (w_strb_rise),
        .o_fall  (w_strb_fall)
    );

    // ---------------------------------------------------------------- state
    strobe_mon_state_t r_state;
    strobe_mon_state_t w_state_nxt;

    logic [31:0] r_lat_cnt;
    logic [31:0] r_wid_cnt;
    logic [31:0] r_trig_idx;

    logic [31:0] r_strobe_latency;
    logic        r_latency_valid;
    logic [31:0] r_strobe_width;
    logic        r_width_valid;
    logic [31:0] r_frame_cnt;
    logic [31:0] r_miss_cnt;
    logic [31:0] r_overlap_cnt;
    logic        r_timeout_err;
    logic        r_burst_done;
    logic        r_busy;

    // ------------------------------------------------------ FSM decisions
    logic        w_take;        // accept a new trigger, restart latency
    logic        w_lat_report;  // strobe received
    logic        w_wid_report;  // strobe ended
    logic        w_timeout;     // waited too long for the strobe
    logic        w_retrig;      // new trigger before any strobe
    logic        w_overlap;     // new trigger while strobe still high
    logic        w_resolve;     // current trigger resolved (strobe/timeout)
    logic [31:0] w_trig_num;
    logic        w_burst_last;
    logic [31:0] w_lat_next;

    assign w_trig_num   = (bus.reg_camera_trig_num == 32'd0) ? 32'd1
                                                             : bus.reg_camera_trig_num;
    assign w_burst_last = (r_trig_idx >= w_trig_num);
    assign w_lat_next   = sat_inc(r_lat_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_take       = 1'b0;
        w_lat_report = 1'b0;
        w_wid_report = 1'b0;
        w_timeout    = 1'b0;
        w_retrig     = 1'b0;
        w_overlap    = 1'b0;
        w_resolve    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trig_rise) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_WAIT_STROBE;
                end
            end
            ST_WAIT_STROBE: begin
                // A strobe landing on the timeout cycle wins over the timeout.
                if (w_strb_rise) begin
                    w_lat_report = 1'b1;
                    w_resolve    = 1'b1;
                    w_state_nxt  = ST_IN_STROBE;
                end else if ((bus.reg_strobe_timeout != 32'd0) &&
                             (w_lat_next == bus.reg_strobe_timeout)) begin
                    w_timeout   = 1'b1;
                    w_resolve   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_trig_rise) begin
                    w_retrig = 1'b1;
                    w_take   = 1'b1;
                end
            end
            ST_IN_STROBE: begin
                if (w_strb_fall) begin
                    w_wid_report = 1'b1;
                    w_state_nxt  = ST_IDLE;
                    // Width is reported first; a coincident trigger is then
                    // taken normally and is not an overlap.
                    if (w_trig_rise) begin
                        w_take      = 1'b1;
                        w_state_nxt = ST_WAIT_STROBE;
                    end
                end else if (w_trig_rise) begin
                    w_overlap   = 1'b1;
                    w_take      = 1'b1;
                    w_state_nxt = ST_WAIT_STROBE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // -------------------------------------------- measurements and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig_q         <= 1'b0;
            r_lat_cnt        <= '0;
            r_wid_cnt        <= '0;
            r_trig_idx       <= '0;
            r_strobe_latency <= '0;
            r_latency_valid  <= 1'b0;
            r_strobe_width   <= '0;
            r_width_valid    <= 1'b0;
            r_frame_cnt      <= '0;
            r_miss_cnt       <= '0;
            r_overlap_cnt    <= '0;
            r_timeout_err    <= 1'b0;
            r_burst_done     <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            r_trig_q <= bus.trig_to_camera;

            if (w_take) begin
                r_lat_cnt <= '0;
            end else if (r_state == ST_WAIT_STROBE) begin
                r_lat_cnt <= w_lat_next;
            end

            // The strobe has already been high for one synchronized cycle
            // when its rise is seen, hence the restart at 1.
            if (w_lat_report) begin
                r_wid_cnt <= 32'd1;
            end else if (r_state == ST_IN_STROBE) begin
                r_wid_cnt <= sat_inc(r_wid_cnt);
            end

            // A retrigger closes out the previous trigger as missed; if that
            // one ended the burst, the new trigger starts the next burst.
            if (w_retrig) begin
                r_trig_idx <= w_burst_last ? 32'd1 : sat_inc(r_trig_idx);
            end else if (w_resolve) begin
                if (w_burst_last) begin
                    r_trig_idx <= '0;
                end
            end else if (w_take) begin
                r_trig_idx <= sat_inc(r_trig_idx);
            end

            r_burst_done    <= (w_resolve | w_retrig) & w_burst_last;
            r_latency_valid <= w_lat_report;
            r_width_valid   <= w_wid_report;
            r_timeout_err   <= w_timeout;
            r_busy          <= (w_state_nxt != ST_IDLE);

            if (w_lat_report) begin
                r_strobe_latency <= w_lat_next;
            end
            if (w_wid_report) begin
                r_strobe_width <= r_wid_cnt;
            end

            // Clear beats a coincident increment.
            if (bus.clear) begin
                r_frame_cnt <= '0;
            end else if (w_lat_report) begin
                r_frame_cnt <= sat_inc(r_frame_cnt);
            end

            if (bus.clear) begin
                r_miss_cnt <= '0;
            end else if (w_timeout | w_retrig) begin
                r_miss_cnt <= sat_inc(r_miss_cnt);
            end

            if (bus.clear) begin
                r_overlap_cnt <= '0;
            end else if (w_overlap) begin
                r_overlap_cnt <= sat_inc(r_overlap_cnt);
            end
        end
    end

    assign bus.strobe_latency = r_strobe_latency;
    assign bus.latency_valid  = r_latency_valid;
    assign bus.strobe_width   = r_strobe_width;
    assign bus.width_valid    = r_width_valid;
    assign bus.frame_cnt      = r_frame_cnt;
    assign bus.miss_cnt       = r_miss_cnt;
    assign bus.overlap_cnt    = r_overlap_cnt;
    assign bus.timeout_err    = r_timeout_err;
    assign bus.burst_done     = r_burst_done;
    assign bus.busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_camera_strobe_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_camera_strobe_monitor
//  Description : Self-checking bench for camera_strobe_monitor. Each trigger
//                is described as a transaction (strobe delay k, strobe width
//                w, timeout); the expected latency, width, counts and burst
//                completion are computed from those numbers.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_camera_strobe_monitor;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    camera_strobe_monitor_if bus();

    camera_strobe_monitor #(
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // ------------------------------------------------------ pulse monitor
    int          cyc = 0;
    int          n_lat = 0, n_wid = 0, n_to = 0, n_bd = 0;
    int          lat_cyc = 0, to_cyc = 0;
    logic [31:0] last_lat = '0, last_wid = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.latency_valid) begin
            n_lat++;
            last_lat = bus.strobe_latency;
            lat_cyc  = cyc;
        end
        if (bus.width_valid) begin
            n_wid++;
            last_wid = bus.strobe_width;
        end
        if (bus.timeout_err) begin
            n_to++;
            to_cyc = cyc;
        end
        if (bus.burst_done) n_bd++;
    end

    // ------------------------------------------------------ reference model
    logic [31:0] m_frame = '0, m_miss = '0, m_ov = '0;
    logic [31:0] m_idx = '0, m_num = 32'd1;

    function automatic logic [31:0] sat1(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] eff(input logic [31:0] n);
        return (n == 32'd0) ? 32'd1 : n;
    endfunction

    // ------------------------------------------------------ helpers
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic trig_pulse(output int c0);
        bus.trig_to_camera = 1'b1;
        tick();
        c0 = cyc;
        bus.trig_to_camera = 1'b0;
    endtask

    task automatic set_num(input logic [31:0] n);
        bus.reg_camera_trig_num = n;
        m_num = n;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_frame"},   bus.frame_cnt,   m_frame);
        check({tag, "_miss"},    bus.miss_cnt,    m_miss);
        check({tag, "_overlap"}, bus.overlap_cnt, m_ov);
        check({tag, "_busy"},    32'(bus.busy),   32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_lat"},   bus.strobe_latency, 32'd0);
        check({tag, "_wid"},   bus.strobe_width,   32'd0);
        check({tag, "_frame"}, bus.frame_cnt,      32'd0);
        check({tag, "_miss"},  bus.miss_cnt,       32'd0);
        check({tag, "_ovl"},   bus.overlap_cnt,    32'd0);
        check({tag, "_flags"},
              32'({bus.latency_valid, bus.width_valid, bus.timeout_err,
                   bus.burst_done, bus.busy}), 32'd0);
    endtask

    // One trigger; the strobe pin is first sampled high k edges after the
    // trigger edge and stays high for w sampled edges.
    task automatic frame_txn(input string tag, input int k, input int w, input int tmo);
        int   lat0, wid0, to0, bd0, c0;
        logic got, exp_bd;
        bus.reg_strobe_timeout = 32'(tmo);
        lat0 = n_lat; wid0 = n_wid; to0 = n_to; bd0 = n_bd;
        got  = (tmo == 0) || (tmo >= k + SYNC);
        m_idx = sat1(m_idx);
        exp_bd = (m_idx >= eff(m_num));
        if (exp_bd) m_idx = '0;
        if (got) m_frame = sat1(m_frame);
        else     m_miss  = sat1(m_miss);

        trig_pulse(c0);
        ticks(k - 1);
        bus.camera_strobe = 1'b1;
        ticks(w);
        bus.camera_strobe = 1'b0;
        ticks(8);

        check({tag, "_latpulses"}, n_lat - lat0, got ? 1 : 0);
        check({tag, "_widpulses"}, n_wid - wid0, got ? 1 : 0);
        check({tag, "_topulses"},  n_to - to0,   got ? 0 : 1);
        check({tag, "_burst"},     n_bd - bd0,   exp_bd ? 1 : 0);
        if (got) begin
            check({tag, "_latency"}, last_lat,     32'(k + SYNC));
            check({tag, "_latcyc"},  lat_cyc - c0, k + SYNC);
            check({tag, "_width"},   last_wid,     32'(w));
        end else begin
            check({tag, "_tocyc"},   to_cyc - c0,  tmo);
        end
        check_counters(tag);
    endtask

    // ------------------------------------------------------ stimulus
    initial begin : main
        int c0, c1, lat0, wid0, to0, bd0;
        int k, w, tmo, sel;

        rst = 1'b1;
        bus.trig_to_camera      = 1'b0;
        bus.camera_strobe       = 1'b0;
        bus.reg_strobe_timeout  = 32'd0;
        bus.reg_camera_trig_num = 32'd1;
        bus.clear               = 1'b0;
        ticks(3);
        check_all_zero("reset");
        rst = 1'b0;
        ticks(2);

        // Basic frame and plain timeout.
        set_num(32'd1);
        frame_txn("basic", 10, 20, 100);
        frame_txn("timeout50", 60, 5, 50);

        // Bursts of four, then trig_num 0 acting as 1.
        set_num(32'd4);
        for (int i = 0; i < 4; i++) frame_txn("burst4", 3 + i, 2 + i, 0);
        set_num(32'd0);
        for (int i = 0; i < 2; i++) frame_txn("burst0", 4, 3, 100);

        // Strobe exactly on the timeout cycle counts as a frame.
        set_num(32'd1);
        frame_txn("edge_to", 8, 3, 8 + SYNC);

        // Second trigger while the strobe is still high.
        bus.reg_strobe_timeout = 32'd100;
        lat0 = n_lat; wid0 = n_wid; to0 = n_to; bd0 = n_bd;
        trig_pulse(c0);
        ticks(2);  bus.camera_strobe = 1'b1;
        ticks(7);  trig_pulse(c1);
        tick();    bus.camera_strobe = 1'b0;
        ticks(3);  bus.camera_strobe = 1'b1;
        ticks(4);  bus.camera_strobe = 1'b0;
        ticks(8);
        m_frame = sat1(sat1(m_frame));
        m_ov    = sat1(m_ov);
        check("ovl_latpulses", n_lat - lat0, 2);
        check("ovl_widpulses", n_wid - wid0, 1);
        check("ovl_latency",   last_lat, 32'd7);
        check("ovl_latcyc",    lat_cyc - c1, 7);
        check("ovl_width",     last_wid, 32'd4);
        check("ovl_burst",     n_bd - bd0, 2);
        check("ovl_to",        n_to - to0, 0);
        check_counters("ovl");

        // Retrigger while still waiting for the strobe.
        lat0 = n_lat; wid0 = n_wid; bd0 = n_bd;
        trig_pulse(c0);
        ticks(4);  trig_pulse(c1);
        ticks(2);  bus.camera_strobe = 1'b1;
        ticks(2);  bus.camera_strobe = 1'b0;
        ticks(8);
        m_miss  = sat1(m_miss);
        m_frame = sat1(m_frame);
        check("retrig_latency", last_lat, 32'd5);
        check("retrig_latcyc",  lat_cyc - c1, 5);
        check("retrig_width",   last_wid, 32'd2);
        check("retrig_burst",   n_bd - bd0, 2);
        check_counters("retrig");

        // Randomized transactions against the model.
        for (int g = 0; g < 6; g++) begin
            set_num(32'($urandom_range(0, 4)));
            for (int i = 0; i < 5; i++) begin
                k   = int'($urandom_range(1, 15));
                w   = int'($urandom_range(1, 12));
                sel = int'($urandom_range(0, 3));
                case (sel)
                    0:       tmo = 0;
                    1:       tmo = int'($urandom_range(k + SYNC + 1, 200));
                    2:       tmo = k + SYNC;
                    default: tmo = int'($urandom_range(1, k + SYNC - 1));
                endcase
                frame_txn("rand", k, w, tmo);
            end
        end

        // Clear coinciding with a frame_cnt increment.
        set_num(32'd1);
        m_idx = '0;
        bus.reg_strobe_timeout = 32'd100;
        lat0 = n_lat;
        trig_pulse(c0);
        ticks(4);  bus.camera_strobe = 1'b1;
        ticks(2);  bus.clear = 1'b1;
        tick();    bus.clear = 1'b0;
        tick();    bus.camera_strobe = 1'b0;
        ticks(8);
        m_frame = '0; m_miss = '0; m_ov = '0;
        check("clear_latpulses", n_lat - lat0, 1);
        check("clear_latency",   last_lat, 32'd7);
        check("clear_width",     last_wid, 32'd4);
        check_counters("clear");

        // Reset in the middle of a wait; frame_cnt is non-zero beforehand.
        frame_txn("pre_rst", 5, 3, 100);
        trig_pulse(c0);
        ticks(3);
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        m_frame = '0; m_miss = '0; m_ov = '0; m_idx = '0;
        lat0 = n_lat; to0 = n_to; bd0 = n_bd;
        ticks(12);
        check("midrst_quiet", (n_lat - lat0) + (n_to - to0) + (n_bd - bd0), 0);
        frame_txn("post_rst", 6, 5, 100);

        // Saturation of miss_cnt.
        force dut.r_miss_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_miss_cnt;
        m_miss = 32'hFFFF_FFFE;
        frame_txn("sat1", 20, 3, 5);
        frame_txn("sat2", 20, 3, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
